// File: rtl/fsm_line_controller.sv
// Operator-side line supervisor sequencing a fill/seal station through batches of BATCH_SIZE products.
// Optional macro LINE_STATS_EN adds a saturating lifetime total_sealed counter output.
module fsm_line_controller #(
  parameter int BATCH_SIZE = 4,
  parameter int TIMEOUT    = 8,
  localparam int CW        = $clog2(BATCH_SIZE + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          llenando,
  input  logic          sellando,
  input  logic          sealed,
  output logic          startfill,
  output logic          productook,
  output logic          batch_done,
  output logic          fault,
  output logic [CW-1:0] count,
  output logic [2:0]    state_ctrl
`ifdef LINE_STATS_EN
  ,
  output logic [7:0]    total_sealed
`endif
);

  localparam int WW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE      = 3'b000,
    REQ_FILL  = 3'b001,
    WAIT_FILL = 3'b010,
    PRESENT   = 3'b011,
    WAIT_SEAL = 3'b100,
    NEXT      = 3'b101,
    DONE      = 3'b110,
    FAULT     = 3'b111
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] count_n;
  logic [WW-1:0] wdog, wdog_n;
  logic          expired;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Wait states share one rule: abort beats exit event, exit event beats expiry.
  function automatic state_t wait_next(input state_t cur, input state_t nxt,
                                       input logic go, input logic ev, input logic exp);
    if (!go)      return IDLE;
    else if (ev)  return nxt;
    else if (exp) return FAULT;
    else          return cur;
  endfunction

  assign expired = (wdog == WW'(TIMEOUT - 1));

  always_comb begin
    state_n = state;
    count_n = count;
    wdog_n  = wdog;
    case (state)
      IDLE: begin
        if (run) begin
          state_n = REQ_FILL;
          count_n = '0;
        end
      end
      REQ_FILL:  state_n = wait_next(state, WAIT_FILL, run, llenando,  expired);
      WAIT_FILL: state_n = wait_next(state, PRESENT,   run, !llenando, expired);
      PRESENT:   state_n = wait_next(state, WAIT_SEAL, run, sellando,  expired);
      WAIT_SEAL: state_n = wait_next(state, NEXT,      run, sealed,    expired);
      NEXT: begin
        if (!run) begin
          state_n = IDLE;
        end else begin
          count_n = count + 1'b1;
          state_n = (count_n == CW'(BATCH_SIZE)) ? DONE : REQ_FILL;
        end
      end
      DONE:    if (!run) state_n = IDLE;
      FAULT:   if (!run) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (state_n != state) wdog_n = '0;
    else if (state inside {REQ_FILL, WAIT_FILL, PRESENT, WAIT_SEAL}) wdog_n = wdog + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      wdog  <= '0;
    end else begin
      state <= state_n;
      count <= count_n;
      wdog  <= wdog_n;
    end
  end

`ifdef LINE_STATS_EN
  logic stat_inc;
  assign stat_inc = (state == WAIT_SEAL) && (state_n == NEXT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           total_sealed <= 8'd0;
    else if (stat_inc) total_sealed <= sat_inc8(total_sealed);
  end
`endif

  // Moore decode straight from the state register.
  assign startfill  = (state == REQ_FILL);
  assign productook = (state == PRESENT) || (state == WAIT_SEAL);
  assign batch_done = (state == DONE);
  assign fault      = (state == FAULT);
  assign state_ctrl = state;

endmodule

// File: tb/tb_fsm_line_controller.sv
// Self-checking bench: directed scenarios plus biased random station behaviour against a phase-level model.
module tb_fsm_line_controller;

  localparam int B  = 4;
  localparam int T  = 8;
  localparam int CW = $clog2(B + 1);

  logic clk = 1'b0;
  logic rst, run, llenando, sellando, sealed;
  logic startfill, productook, batch_done, fault;
  logic [CW-1:0] count;
  logic [2:0] state_ctrl;
`ifdef LINE_STATS_EN
  logic [7:0] total_sealed;
`endif

  int checks = 0;
  int failures = 0;

  // Reference model: phase number (spec encoding), products sealed, lifetime total, cycles in phase.
  int ph, cnt, tot, age;
  int mode;

  fsm_line_controller #(.BATCH_SIZE(B), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .run(run),
    .llenando(llenando), .sellando(sellando), .sealed(sealed),
    .startfill(startfill), .productook(productook), .batch_done(batch_done),
    .fault(fault), .count(count), .state_ctrl(state_ctrl)
`ifdef LINE_STATS_EN
    , .total_sealed(total_sealed)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":state"},      16'(state_ctrl), 16'(ph));
    chk({tag, ":startfill"},  16'(startfill),  16'(ph == 1));
    chk({tag, ":productook"}, 16'(productook), 16'(ph == 3 || ph == 4));
    chk({tag, ":batch_done"}, 16'(batch_done), 16'(ph == 6));
    chk({tag, ":fault"},      16'(fault),      16'(ph == 7));
    chk({tag, ":count"},      16'(count),      16'(cnt));
`ifdef LINE_STATS_EN
    chk({tag, ":total"},      16'(total_sealed), 16'(tot));
`endif
  endtask

  function automatic bit exit_ev(input int p);
    case (p)
      1:       return llenando;
      2:       return !llenando;
      3:       return sellando;
      4:       return sealed;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_edge();
    int np;
    if (rst) begin
      ph = 0; cnt = 0; tot = 0; age = 0;
      return;
    end
    np = ph;
    if (ph == 0) begin
      if (run) begin np = 1; cnt = 0; end
    end else if (ph <= 5 && !run) begin
      np = 0;
    end else if (ph <= 4) begin
      if (exit_ev(ph)) begin
        np = ph + 1;
        if (np == 5 && tot < 255) tot++;
      end else if (age == T - 1) begin
        np = 7;
      end
    end else if (ph == 5) begin
      cnt++;
      np = (cnt == B) ? 6 : 1;
    end else if (!run) begin
      np = 0;
    end
    if (np != ph) age = 0; else age++;
    ph = np;
  endtask

  // Station behaviour for the next edge, derived from the model's view of the controller.
  task automatic set_inputs();
    case (mode)
      0, 2: begin
        llenando = (ph == 1 && age >= 1) || (ph == 2 && age < 2);
        sellando = (ph == 3 && age >= 1) || (ph == 4);
        sealed   = (mode == 0) ? (ph == 4 && age >= 1) : (ph == 4 && age == T - 1);
      end
      1: begin
        llenando = 1'b0; sellando = 1'b0; sealed = 1'b0;
      end
      default: begin
        llenando = (ph == 1) ? ($urandom_range(2) == 0) :
                   (ph == 2) ? ($urandom_range(2) != 0) : 1'($urandom);
        sellando = (ph == 3) ? ($urandom_range(2) == 0) : 1'($urandom);
        sealed   = (ph == 4) ? ($urandom_range(2) == 0) : 1'($urandom);
        if (ph >= 6) run = ($urandom_range(3) != 0);
        else         run = ($urandom_range(29) != 0);
      end
    endcase
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
    set_inputs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_edge();
    #1;
    check_all("rst_async");
    @(posedge clk);
    #1;
    check_all("rst_hold");
    rst = 1'b0;
    set_inputs();
  endtask

  initial begin
    int n;
    rst = 1'b0; run = 1'b1; llenando = 1'b0; sellando = 1'b0; sealed = 1'b0;
    ph = 0; cnt = 0; tot = 0; age = 0; mode = 0;
    #2;

    // Reset with run held: first edge after release goes to REQ_FILL.
    do_reset();
    cyc("first");
    chk("first_state", 16'(state_ctrl), 16'd1);
    chk("first_startfill", 16'(startfill), 16'd1);

    // Full batch with a cooperative station.
    n = 0;
    while (ph != 6 && n < 200) begin cyc("batch"); n++; end
    chk("batch_done", 16'(batch_done), 16'd1);
    chk("batch_count", 16'(count), 16'(B));
    chk("batch_state", 16'(state_ctrl), 16'd6);
    run = 1'b0;
    cyc("batch_stop");
    chk("batch_idle", 16'(state_ctrl), 16'd0);

    // Mute station: fault exactly T cycles after REQ_FILL entry, latched until run drops.
    mode = 1; run = 1'b1; set_inputs();
    cyc("mute_entry");
    n = 0;
    while (fault !== 1'b1 && n < 20) begin cyc("mute"); n++; end
    chk("fault_latency", 16'(n), 16'(T));
    repeat (3) cyc("fault_hold");
    chk("fault_latched", 16'(fault), 16'd1);
    run = 1'b0;
    cyc("fault_clear");
    chk("fault_idle", 16'(state_ctrl), 16'd0);

    // sealed arrives on the last watchdog cycle of WAIT_SEAL: NEXT, not FAULT.
    mode = 2; run = 1'b1; set_inputs();
    n = 0;
    while (ph != 5 && n < 60) begin cyc("late_seal"); n++; end
    chk("late_seal_next", 16'(state_ctrl), 16'd5);
    chk("late_seal_nofault", 16'(fault), 16'd0);
    run = 1'b0;
    cyc("late_seal_stop");

    // Abort in WAIT_SEAL with two products done; count holds, then clears on restart.
    mode = 0; run = 1'b1; set_inputs();
    n = 0;
    while (!(ph == 4 && cnt == 2) && n < 100) begin cyc("abort_run"); n++; end
    run = 1'b0;
    cyc("abort");
    chk("abort_state", 16'(state_ctrl), 16'd0);
    chk("abort_productook", 16'(productook), 16'd0);
    chk("abort_count", 16'(count), 16'd2);
    run = 1'b1;
    cyc("restart");
    chk("restart_state", 16'(state_ctrl), 16'd1);
    chk("restart_count", 16'(count), 16'd0);

    // 64 batches drive the lifetime total past saturation.
    for (int b = 0; b < 64; b++) begin
      n = 0;
      while (ph != 6 && n < 200) begin cyc("preload"); n++; end
      run = 1'b0;
      cyc("preload_stop");
      run = 1'b1;
    end
`ifdef LINE_STATS_EN
    chk("total_sat", 16'(total_sealed), 16'd255);
`endif
    repeat (5) cyc("mid_batch");
    do_reset();
    chk("midrst_state", 16'(state_ctrl), 16'd0);
    chk("midrst_count", 16'(count), 16'd0);
`ifdef LINE_STATS_EN
    chk("midrst_total", 16'(total_sealed), 16'd0);
`endif

    // Randomized station and operator behaviour.
    mode = 3; set_inputs();
    repeat (2000) cyc("rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
